// File: rtl/serial_link_reg_master.sv
// rtl/serial_link_reg_master.sv - reg-bus initiator driven by a command/response stream
// One command in flight: IDLE accepts, REQ waits for ready or timeout, RSP holds the response.
module serial_link_reg_master #(
  parameter int unsigned RegAddrWidth  = 32,
  parameter int unsigned RegDataWidth  = 32,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [RegAddrWidth-1:0]   cmd_addr_i,
  input  logic                      cmd_write_i,
  input  logic [RegDataWidth-1:0]   cmd_wdata_i,
  input  logic [RegDataWidth/8-1:0] cmd_wstrb_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [RegDataWidth-1:0]   rsp_rdata_o,
  output logic                      rsp_error_o,
  output logic                      rsp_timeout_o,
  output logic [RegAddrWidth-1:0]   reg_req_addr_o,
  output logic                      reg_req_write_o,
  output logic [RegDataWidth-1:0]   reg_req_wdata_o,
  output logic [RegDataWidth/8-1:0] reg_req_wstrb_o,
  output logic                      reg_req_valid_o,
  input  logic [RegDataWidth-1:0]   reg_rsp_rdata_i,
  input  logic                      reg_rsp_ready_i,
  input  logic                      reg_rsp_error_i,
  output logic                      busy_o
);

  localparam int unsigned StrbWidth = RegDataWidth / 8;
  localparam int unsigned CntWidth  = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntWidth-1:0] CntLast =
    CntWidth'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;

  state_e                  state_q, state_d;
  logic [RegAddrWidth-1:0] addr_q, addr_d;
  logic                    write_q, write_d;
  logic [RegDataWidth-1:0] wdata_q, wdata_d;
  logic [StrbWidth-1:0]    wstrb_q, wstrb_d;
  logic                    req_valid_q, req_valid_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [RegDataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_error_q, rsp_error_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic [CntWidth-1:0]     cnt_q, cnt_d;

  assign cmd_ready_o     = (state_q == IDLE);
  assign busy_o          = (state_q != IDLE);
  assign reg_req_addr_o  = addr_q;
  assign reg_req_write_o = write_q;
  assign reg_req_wdata_o = wdata_q;
  assign reg_req_wstrb_o = wstrb_q;
  assign reg_req_valid_o = req_valid_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_rdata_o     = rsp_rdata_q;
  assign rsp_error_o     = rsp_error_q;
  assign rsp_timeout_o   = rsp_timeout_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    write_d       = write_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    req_valid_d   = req_valid_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          addr_d      = cmd_addr_i;
          write_d     = cmd_write_i;
          wdata_d     = cmd_wdata_i;
          wstrb_d     = cmd_wstrb_i;
          req_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        // Ready outranks a timeout landing on the same cycle.
        if (reg_rsp_ready_i) begin
          addr_d        = '0;
          write_d       = 1'b0;
          wdata_d       = '0;
          wstrb_d       = '0;
          req_valid_d   = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_error_d   = reg_rsp_error_i;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (!write_q && !reg_rsp_error_i) ? reg_rsp_rdata_i : '0;
          state_d       = RSP;
        end else if ((TimeoutCycles != 0) && (cnt_q == CntLast)) begin
          addr_d        = '0;
          write_d       = 1'b0;
          wdata_d       = '0;
          wstrb_d       = '0;
          req_valid_d   = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_error_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
          state_d       = RSP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_d   = 1'b0;
          rsp_rdata_d   = '0;
          rsp_error_d   = 1'b0;
          rsp_timeout_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      req_valid_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      write_q       <= write_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      req_valid_q   <= req_valid_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_link_reg_master.sv
// tb/tb_serial_link_reg_master.sv - bench for serial_link_reg_master
// Runs with TimeoutCycles=4 so timeouts are cheap to reach.
module tb_serial_link_reg_master;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_timeout;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        req_valid;
  logic [31:0] bus_rdata = '0;
  logic        bus_ready = 1'b0;
  logic        bus_error = 1'b0;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_link_reg_master #(
    .RegAddrWidth(32), .RegDataWidth(32), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_addr_i(cmd_addr), .cmd_write_i(cmd_write),
    .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_error_o(rsp_error), .rsp_timeout_o(rsp_timeout),
    .reg_req_addr_o(req_addr), .reg_req_write_o(req_write),
    .reg_req_wdata_o(req_wdata), .reg_req_wstrb_o(req_wstrb),
    .reg_req_valid_o(req_valid),
    .reg_rsp_rdata_i(bus_rdata), .reg_rsp_ready_i(bus_ready), .reg_rsp_error_i(bus_error),
    .busy_o(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          wait_n;
    logic [31:0] rd;
    logic        er;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_vc;
  } vec_t;

  // Drives one command, a responder that raises ready after wait_n request cycles
  // (never, once the request has gone away), and consumes the response.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int wait_n, input logic [31:0] rd,
                         input logic er, output logic a_valid, output logic [31:0] a_rdata,
                         output logic a_err, output logic a_to, output int vc,
                         output logic fields_ok, output logic clear_ok);
    @(negedge clk);
    fields_ok = cmd_ready;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = wstrb;
    vc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0; bus_ready = 1'b0; bus_error = 1'b0; bus_rdata = '0;
      if (!req_valid) break;
      vc++;
      if (req_addr !== addr || req_write !== wr || req_wdata !== wdata || req_wstrb !== wstrb
          || !busy || cmd_ready)
        fields_ok = 1'b0;
      if (c == wait_n) begin
        bus_ready = 1'b1; bus_error = er; bus_rdata = rd;
      end
    end
    a_valid = rsp_valid; a_rdata = rsp_rdata; a_err = rsp_error; a_to = rsp_timeout;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    clear_ok = !rsp_valid && rsp_rdata == 0 && !rsp_error && !rsp_timeout && !req_valid
               && req_addr == 0 && req_wdata == 0 && req_wstrb == 0 && !busy && cmd_ready;
  endtask

  task automatic apply(input string tag, input vec_t v);
    logic        a_valid, a_err, a_to, f_ok, c_ok;
    logic [31:0] a_rdata;
    int          vc;
    run_txn(v.wr, v.addr, v.wdata, v.wstrb, v.wait_n, v.rd, v.er,
            a_valid, a_rdata, a_err, a_to, vc, f_ok, c_ok);
    chk({tag, "_rsp_valid"}, a_valid, 1);
    chk({tag, "_rdata"}, a_rdata, v.exp_rdata);
    chk({tag, "_error"}, a_err, v.exp_err);
    chk({tag, "_timeout"}, a_to, v.exp_to);
    chk({tag, "_req_cycles"}, vc, v.exp_vc);
    chk({tag, "_req_fields"}, f_ok, 1);
    chk({tag, "_cleared"}, c_ok, 1);
  endtask

  // Reference: outcome follows from how long the responder waits versus the timeout.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (v.wait_n >= TO) begin
      r.exp_rdata = 0; r.exp_err = 1; r.exp_to = 1; r.exp_vc = TO;
    end else begin
      r.exp_err = v.er; r.exp_to = 0; r.exp_vc = v.wait_n + 1;
      r.exp_rdata = (!v.wr && !v.er) ? v.rd : 32'h0;
    end
    return r;
  endfunction

  vec_t vecs[8];
  logic [31:0] hold_rdata;
  logic        stable_ok;

  initial begin
    vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'hAAAA5555, 1'b0, 32'h0, 1'b0, 1'b0, 1};
    vecs[1] = '{1'b0, 32'h20, 32'h0, 4'h0, 3, 32'h12345678, 1'b0, 32'h12345678, 1'b0, 1'b0, 4};
    vecs[2] = '{1'b0, 32'h24, 32'h11, 4'h3, 1, 32'h0000FFFF, 1'b1, 32'h0, 1'b1, 1'b0, 2};
    vecs[3] = '{1'b1, 32'h28, 32'h55AA, 4'h1, 2, 32'h77777777, 1'b1, 32'h0, 1'b1, 1'b0, 3};
    vecs[4] = '{1'b0, 32'h2C, 32'h0, 4'hF, 10, 32'h99999999, 1'b0, 32'h0, 1'b1, 1'b1, 4};
    vecs[5] = '{1'b1, 32'h30, 32'h1234, 4'h8, 4, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 4};
    vecs[6] = '{1'b0, 32'h34, 32'h0, 4'h0, 0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 1};
    vecs[7] = '{1'b0, 32'hFFFFFFFC, 32'hA5A5A5A5, 4'h6, 2, 32'h80000001, 1'b0, 32'h80000001, 1'b0, 1'b0, 3};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_req_valid", req_valid, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_fields", {rsp_rdata, rsp_error, rsp_timeout}, 0);
    chk("reset_req_fields", {req_addr, req_wdata, req_wstrb, req_write}, 0);

    for (int i = 0; i < 8; i++) apply($sformatf("vec%0d", i), vecs[i]);

    // Response backpressure: fields hold and no command is accepted.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40;
    @(negedge clk);
    cmd_valid = 1'b0; bus_ready = 1'b1; bus_rdata = 32'h0BADF00D;
    @(negedge clk);
    bus_ready = 1'b0; bus_rdata = '0;
    chk("bp_rsp_valid", rsp_valid, 1);
    hold_rdata = rsp_rdata;
    chk("bp_rdata", hold_rdata, 32'h0BADF00D);
    stable_ok = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 32'h44;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== hold_rdata || rsp_error || rsp_timeout || cmd_ready
          || req_valid)
        stable_ok = 1'b0;
    end
    chk("bp_stable", stable_ok, 1);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_idle", {busy, cmd_ready, rsp_valid}, 3'b010);

    // Stray ready after a timeout is ignored.
    apply("to_stray", model('{1'b0, 32'h50, 32'h0, 4'h0, 9, 32'h1, 1'b0, 32'h0, 1'b0, 1'b0, 0}));
    stable_ok = 1'b1;
    bus_ready = 1'b1; bus_error = 1'b1; bus_rdata = 32'hFFFFFFFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rsp_valid || busy || req_valid || rsp_error || rsp_rdata != 0) stable_ok = 1'b0;
    end
    bus_ready = 1'b0; bus_error = 1'b0; bus_rdata = '0;
    chk("stray_ignored", stable_ok, 1);

    // Asynchronous reset while the request is outstanding.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h60; cmd_wdata = 32'h1; cmd_wstrb = 4'h1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rst_pre_req_valid", req_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_async", {req_valid, rsp_valid, busy, req_addr}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_rst", model('{1'b0, 32'h64, 32'h0, 4'h0, 1, 32'h31415926, 1'b0, 32'h0, 1'b0, 1'b0, 0}));

    // Randomized transactions against the reference model.
    for (int n = 0; n < 40; n++) begin
      vec_t v;
      v.wr = 1'($urandom_range(0, 1));
      v.addr = $urandom(); v.wdata = $urandom(); v.wstrb = 4'($urandom_range(0, 15));
      v.wait_n = $urandom_range(0, 6); v.rd = $urandom(); v.er = ($urandom_range(0, 3) == 0);
      apply($sformatf("rnd%0d", n), model(v));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_link_reg_master.md
Name: serial_link_reg_master

Overview:
Register-bus initiator that drives the configuration port of the serial link (and any other reg-bus responder) from a simple command/response stream. It is the requester end of the reg-bus protocol whose responder is the serial link's cfg port. It accepts one command at a time, issues it as a reg-bus request, waits for the handshake or a timeout, and returns read data and status on a response stream.

Parameters:
RegAddrWidth, 32, reg-bus address width
RegDataWidth, 32, reg-bus data width; must be a multiple of 8
TimeoutCycles, 256, max cycles a request may wait for ready; 0 disables timeout

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_addr_i  in  RegAddrWidth  command address
cmd_write_i  in  1  1=write, 0=read
cmd_wdata_i  in  RegDataWidth  write data
cmd_wstrb_i  in  RegDataWidth/8  write byte strobes
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&ready
rsp_rdata_o  out  RegDataWidth  read data; 0 for writes, errors and timeouts
rsp_error_o  out  1  responder error or timeout
rsp_timeout_o  out  1  request abandoned by timeout
reg_req_addr_o  out  RegAddrWidth  reg-bus address
reg_req_write_o  out  1  reg-bus write
reg_req_wdata_o  out  RegDataWidth  reg-bus write data
reg_req_wstrb_o  out  RegDataWidth/8  reg-bus strobes
reg_req_valid_o  out  1  reg-bus request valid
reg_rsp_rdata_i  in  RegDataWidth  reg-bus read data
reg_rsp_ready_i  in  1  reg-bus ready (completes transfer with valid)
reg_rsp_error_i  in  1  reg-bus error, sampled with ready
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: clk_i is the only clock; rst_ni is asynchronous and active-low.
- Reset: FSM enters IDLE. All reg_req_* outputs, all rsp_* outputs, the command registers and the timeout counter are 0. cmd_ready_o reads 1 once rst_ni is deasserted.
- FSM states: IDLE, REQ, RSP.
- All outputs are registered except cmd_ready_o and busy_o, which are state decodes.

IDLE state:
- cmd_ready_o=1; all other outputs are at their reset/idle values.
- On cmd_valid_i (the handshake): capture addr, write, wdata and wstrb into the reg_req_* registers; set reg_req_valid_o=1; clear the timeout counter; go to REQ on the next edge.
- For reads, reg_req_wdata_o and reg_req_wstrb_o carry the captured values unchanged.

REQ state:
- reg_req_valid_o=1; the reg_req_* fields stay stable until the state is left.
- If reg_rsp_ready_i=1:
  - transfer completes; drop reg_req_valid_o.
  - capture rsp_error_o=reg_rsp_error_i and rsp_timeout_o=0.
  - capture rsp_rdata_o=reg_rsp_rdata_i only for a read with no error; otherwise rsp_rdata_o=0.
  - set rsp_valid_o=1; go to RSP.
- Else if TimeoutCycles!=0 and the counter equals TimeoutCycles-1:
  - drop reg_req_valid_o; set rsp_error_o=1, rsp_timeout_o=1, rsp_rdata_o=0, rsp_valid_o=1; go to RSP.
  - Ready arriving on the same cycle as the timeout wins: it is treated as a normal completion.
- Else: the counter increments; it saturates and never wraps.

RSP state:
- rsp_* outputs are held stable while rsp_valid_o=1 and rsp_ready_i=0.
- On rsp_ready_i: clear rsp_valid_o and the other rsp_* outputs; go to IDLE.
- reg_rsp_ready_i seen outside REQ (a late response after a timeout) is ignored.

Latency and throughput:
- Command accepted at cycle 0 -> reg_req_valid_o=1 at cycle 1.
- Zero-wait responder (ready at cycle 1) -> rsp_valid_o=1 at cycle 2.
- With rsp_ready_i tied high, IDLE is reached again at cycle 3, so the next command can be accepted at cycle 3.
- Maximum throughput: one transaction per 3 cycles. At most one transaction is outstanding.

Reset mid-operation: all state and outputs clear immediately. Any in-flight request and any pending response are discarded without reporting.

Test Plan:
- Write, zero-wait responder: cmd addr=0x10, wdata=0xDEADBEEF, wstrb=0xF, write=1 -> reg_req_valid_o=1 at cycle 1 with matching fields -> rsp_valid_o at cycle 2 with rdata=0, error=0, timeout=0.
- Read with 3 wait cycles: responder returns rdata=0x12345678 when ready rises at cycle 4 -> request fields stable cycles 1-4 -> rsp at cycle 5 with rdata=0x12345678, error=0.
- Error: responder asserts ready and error on a read -> rsp_error_o=1, rsp_rdata_o=0, rsp_timeout_o=0.
- Response backpressure: rsp_ready_i low for 5 cycles -> rsp fields stable and cmd_ready_o=0 throughout -> IDLE on the cycle after rsp_ready_i rises.
- Timeout, TimeoutCycles=4, ready never asserted: reg_req_valid_o high for exactly 4 cycles -> rsp error=1, timeout=1 -> a later stray ready is ignored.
- Reset mid-REQ: assert rst_ni=0 at cycle 2 -> reg_req_valid_o=0, rsp_valid_o=0 and busy_o=0 immediately (asynchronously) -> after release a new command completes normally.
